// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between fetch and data requesters.
// Latency: request sampled in IDLE at cycle t -> command t+1..t+MEM_LATENCY, ready pulse at t+MEM_LATENCY.
// Backpressure: requesters hold req until their ready pulse; data wins unless fetch has been starved MAX_DM_BURST grants.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_DM_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_flush,
  output logic        o_if_ready,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_ready,
  output logic [31:0] o_dm_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT  = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  dm_streak_q, dm_streak_d;
  logic        if_kill_q, if_kill_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_ren_q, mem_ren_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;

  logic        last_cyc;
  logic        fetch_ok;
  logic        fetch_force;
  logic        grant_if;
  logic        grant_dm;

  // Arbitration decision and end-of-access detection.
  always_comb begin
    last_cyc    = (state_q != IDLE) && (cnt_q == LAST_CNT);
    fetch_ok    = i_if_req && !i_flush;
    fetch_force = fetch_ok && (dm_streak_q == BURST_MAX);
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    if (state_q == IDLE) begin
      if (fetch_force) begin
        grant_if = 1'b1;
      end else if (i_dm_req) begin
        grant_dm = 1'b1;
      end else if (fetch_ok) begin
        grant_if = 1'b1;
      end
    end
  end

  // Next-state: grant latches the command, access counts down, last cycle drops back to IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dm_streak_d = dm_streak_q;
    if_kill_d   = if_kill_q;
    mem_addr_d  = mem_addr_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;

    if (grant_if) begin
      state_d     = IF_ACC;
      cnt_d       = 4'd0;
      if_kill_d   = 1'b0;
      dm_streak_d = 4'd0;
      mem_addr_d  = i_if_addr;
      mem_ren_d   = 1'b1;
      mem_wen_d   = 1'b0;
      mem_wdata_d = 32'd0;
      mem_mask_d  = 4'hF;
    end else if (grant_dm) begin
      state_d     = DM_ACC;
      cnt_d       = 4'd0;
      if_kill_d   = 1'b0;
      mem_addr_d  = i_dm_addr;
      mem_ren_d   = !i_dm_we;
      mem_wen_d   = i_dm_we;
      mem_wdata_d = i_dm_wdata;
      mem_mask_d  = i_dm_mask;
      // Count data grants that made a waiting fetch stand aside.
      if (i_if_req) begin
        dm_streak_d = (dm_streak_q == BURST_MAX) ? dm_streak_q : dm_streak_q + 4'd1;
      end else begin
        dm_streak_d = 4'd0;
      end
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 4'd1;
      // A flush kills the fetch response but lets the memory access finish.
      if ((state_q == IF_ACC) && i_flush) begin
        if_kill_d = 1'b1;
      end
      if (last_cyc) begin
        state_d   = IDLE;
        cnt_d     = 4'd0;
        mem_ren_d = 1'b0;
        mem_wen_d = 1'b0;
      end
    end
  end

  // State and command registers; reset abandons any access in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      dm_streak_q <= 4'd0;
      if_kill_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'd0;
      mem_mask_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dm_streak_q <= dm_streak_d;
      if_kill_q   <= if_kill_d;
      mem_addr_q  <= mem_addr_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
    end
  end

  // Ready pulses in the last access cycle; read data gated to zero outside them and for stores.
  always_comb begin
    o_dm_ready  = (state_q == DM_ACC) && last_cyc;
    o_if_ready  = (state_q == IF_ACC) && last_cyc && !if_kill_q && !i_flush;
    o_dm_rdata  = (o_dm_ready && !mem_wen_q) ? i_mem_rdata : 32'd0;
    o_if_rdata  = o_if_ready ? i_mem_rdata : 32'd0;
    o_mem_addr  = mem_addr_q;
    o_mem_ren   = mem_ren_q;
    o_mem_wen   = mem_wen_q;
    o_mem_wdata = mem_wdata_q;
    o_mem_mask  = mem_mask_q;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Grants one requester at a time and drives the memory command for exactly MEM_LATENCY cycles.
- Returns a one-cycle ready pulse with read data to the granted requester; requesters stall until they see ready.
- Gives data accesses priority over fetch, with a bounded-starvation rule, and lets a pipeline flush kill an in-flight fetch response.

Parameters:
MEM_LATENCY, 2, cycles the memory command is held per access; read data is valid in the last cycle; legal range 1..15.
MAX_DM_BURST, 4, consecutive data grants allowed while fetch is waiting before fetch is forced through; legal range 1..15.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_if_req  in  1  fetch request; held with i_if_addr until o_if_ready
i_if_addr  in  32  fetch word address
i_flush  in  1  pipeline flush (branch/jump taken in execute)
o_if_ready  out  1  one-cycle pulse; fetch access complete
o_if_rdata  out  32  instruction; valid only while o_if_ready
i_dm_req  in  1  data request; held with its fields until o_dm_ready
i_dm_we  in  1  1 = store, 0 = load
i_dm_addr  in  32  data address
i_dm_wdata  in  32  store data
i_dm_mask  in  4  byte enables for stores
o_dm_ready  out  1  one-cycle pulse; data access complete
o_dm_rdata  out  32  load data; valid only while o_dm_ready
o_mem_addr  out  32  memory address
o_mem_ren  out  1  memory read enable
o_mem_wen  out  1  memory write enable
o_mem_wdata  out  32  memory write data
o_mem_mask  out  4  memory byte enables
i_mem_rdata  in  32  memory read data; valid in the last access cycle

Behaviour:
- Reset (i_rst low, asynchronous):
  - state = IDLE; cnt = 0; dm_streak = 0; if_kill = 0.
  - All o_mem_* registers = 0.
  - o_if_ready = o_dm_ready = 0.
- States: IDLE, IF_ACC, DM_ACC.
- IDLE, arbitration each cycle, in priority order:
  - (a) fetch_force = i_if_req & ~i_flush & (dm_streak == MAX_DM_BURST) -> IF_ACC.
  - (b) else if i_dm_req -> DM_ACC.
  - (c) else if i_if_req & ~i_flush -> IF_ACC.
  - (d) else stay in IDLE.
- On grant:
  - Register the granted address; for data also register we, wdata and mask. For fetch, mask = 4'hF and wen = 0.
  - Set cnt = 0 and if_kill = 0.
- dm_streak update:
  - +1 (saturating at MAX_DM_BURST) on a data grant while i_if_req is high.
  - Cleared on a fetch grant, or on a data grant while i_if_req is low.
- IF_ACC / DM_ACC:
  - o_mem_ren (load or fetch) or o_mem_wen (store) held high, with address/data/mask stable, for MEM_LATENCY consecutive cycles.
  - cnt increments each cycle.
  - In the cycle cnt == MEM_LATENCY-1 (the last cycle): return to IDLE next cycle, with ren/wen low in that IDLE cycle.
- Ready timing:
  - o_dm_ready = (state == DM_ACC) & last cycle.
  - o_if_ready = (state == IF_ACC) & last cycle & ~if_kill & ~i_flush.
  - Ready is combinational from state and cnt. rdata is passed through combinationally from i_mem_rdata and is 0 when ready is low.
  - Stores also pulse o_dm_ready; o_dm_rdata = 0 for stores.
- Latency: a request sampled in IDLE at cycle t gives memory command cycles t+1..t+MEM_LATENCY and ready at t+MEM_LATENCY. Peak throughput is one access per MEM_LATENCY+1 cycles.
- Flush:
  - i_flush during IF_ACC sets if_kill (sticky until the next grant).
  - The memory access still completes; the fetch ready is suppressed.
  - i_flush in IDLE blocks a fetch grant that cycle only.
  - Flush never affects data accesses.
- Simultaneous events:
  - Both requests in IDLE: data wins unless fetch_force.
  - A request arriving mid-access waits; no pre-emption.
  - A requester that drops req mid-access still receives its ready pulse; the access is not aborted.
- Reset asserted mid-access: the access is abandoned immediately, all outputs go to their reset values, and no ready pulse is issued.
- cnt width is 4 bits; dm_streak width is 4 bits.

Test Plan:
- Single fetch, MEM_LATENCY=2: i_if_req=1 and i_if_addr=0x100 at cycle 0 -> o_mem_ren=1 and o_mem_addr=0x100 in cycles 1-2; o_if_ready=1 with o_if_rdata=i_mem_rdata (0x00500093) in cycle 2; ren=0 in cycle 3.
- Simultaneous requests: fetch 0x104 and load 0x2000 in cycle 0 -> data granted first, o_dm_ready in cycle 2; fetch granted in cycle 3, o_if_ready in cycle 5.
- Store: i_dm_we=1, addr 0x2004, wdata 0xDEADBEEF, mask 4'b0011 -> o_mem_wen=1 with those exact values for 2 cycles; o_dm_ready pulse with o_dm_rdata=0; o_mem_ren stays 0.
- Starvation, MAX_DM_BURST=4: i_dm_req and i_if_req held high continuously -> grant sequence is D,D,D,D,F,D,D,D,D,F; dm_streak returns to 0 after each F.
- Flush: i_flush pulsed in cycle 1 of a fetch access -> o_mem_ren stays high through cycle 2, o_if_ready stays 0; new fetch 0x200 in cycle 3 completes normally.
- Reset: drop i_rst in cycle 1 of a data access -> ren/wen/ready go to 0 asynchronously; after release, state is IDLE and a fresh request completes in MEM_LATENCY cycles.
